// File: rtl/led_frame_scheduler_if.sv
// Producer-side bus of the LED frame scheduler: request/grant arbitration plus pixel fetch.
// The master modport is the scheduler; the slave modport is a frame producer.
interface led_frame_scheduler_if #(
    parameter int unsigned LEDS = 50
);
    localparam int unsigned IDX_W = (LEDS > 1) ? $clog2(LEDS) : 1;

    logic [1:0]       req;
    logic [1:0]       grant;
    logic [IDX_W-1:0] pix_idx;
    logic [23:0]      pix_data;
    logic             done;

    modport master (
        input  req,
        input  pix_data,
        output grant,
        output pix_idx,
        output done
    );

    modport slave (
        output req,
        output pix_data,
        input  grant,
        input  pix_idx,
        input  done
    );
endinterface

// File: rtl/led_frame_scheduler.sv
// Arbitrates two frame producers and shifts granted frames MSB-first into a WS2801 chain,
// then holds CKO low for the latch gap before pulsing done.
module led_frame_scheduler #(
    parameter int unsigned LEDS         = 50,
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned LATCH_CYCLES = 25000
) (
    input  logic                 clk,
    input  logic                 rst,
    led_frame_scheduler_if.master bus,
    output logic                 SDO,
    output logic                 CKO,
    output logic                 busy
);
    localparam int unsigned IDX_W = (LEDS > 1) ? $clog2(LEDS) : 1;
    localparam int unsigned GAP_W = $clog2(LATCH_CYCLES + 1);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [IDX_W-1:0] LAST_PIX = IDX_W'(LEDS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LATCH_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        GAP,
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        LATCH,
        DONE
    } state_t;

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             high_phase;
    logic [4:0]       bit_cnt;
    logic [22:0]      shreg;    // bits still to send; the bit on the wire lives in SDO
    logic             rr_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= GAP;
            gap_cnt     <= '0;
            div_cnt     <= '0;
            high_phase  <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            rr_last     <= 1'b1;
            SDO         <= 1'b0;
            CKO         <= 1'b0;
            busy        <= 1'b1;
            bus.grant   <= '0;
            bus.pix_idx <= '0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                // Post-reset latch gap so a half-shifted frame is latched before anything new.
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                IDLE: begin
                    if (bus.req != 2'b00) begin
                        state       <= FETCH;
                        busy        <= 1'b1;
                        bus.pix_idx <= '0;
                        if (bus.req == 2'b11) begin
                            bus.grant <= rr_last ? 2'b01 : 2'b10;
                            rr_last   <= ~rr_last;
                        end else begin
                            bus.grant <= bus.req;
                        end
                    end
                end

                FETCH: state <= LOAD;

                LOAD: begin
                    SDO        <= bus.pix_data[23];
                    shreg      <= bus.pix_data[22:0];
                    bit_cnt    <= 5'd23;
                    div_cnt    <= '0;
                    high_phase <= 1'b0;
                    CKO        <= 1'b0;
                    state      <= SHIFT;
                end

                // Each bit: CLK_DIV cycles CKO low, then CLK_DIV cycles CKO high; SDO moves only on the fall.
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!high_phase) begin
                            high_phase <= 1'b1;
                            CKO        <= 1'b1;
                        end else begin
                            high_phase <= 1'b0;
                            CKO        <= 1'b0;
                            if (bit_cnt != 5'd0) begin
                                bit_cnt <= bit_cnt - 5'd1;
                                SDO     <= shreg[22];
                                shreg   <= {shreg[21:0], 1'b0};
                            end else if (bus.pix_idx == LAST_PIX) begin
                                SDO     <= 1'b0;
                                gap_cnt <= '0;
                                state   <= LATCH;
                            end else begin
                                bus.pix_idx <= bus.pix_idx + IDX_W'(1);
                                state       <= FETCH;
                            end
                        end
                    end
                end

                LATCH: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt  <= '0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                DONE: begin
                    bus.grant   <= '0;
                    bus.pix_idx <= '0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end

                default: state <= GAP;
            endcase
        end
    end
endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: registered frame producers, a 3-LED WS2801 chain model,
// and a done-triggered scoreboard comparing latched LED contents against queued frames.
module tb_led_frame_scheduler;
    localparam int unsigned LEDS         = 3;
    localparam int unsigned CLK_DIV      = 2;
    localparam int unsigned LATCH_CYCLES = 20;
    localparam int unsigned NBITS        = LEDS * 24;
    localparam int          GRANT_SPAN   = LEDS * (2 + 48 * CLK_DIV) + LATCH_CYCLES + 1;
    localparam int          LATCH_DETECT = 12;  // longer than the 4-cycle inter-pixel low, shorter than the gap

    typedef struct packed {
        logic [1:0]       grant;
        logic [NBITS-1:0] pix;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic SDO, CKO, busy;

    led_frame_scheduler_if #(.LEDS(LEDS)) bus ();

    led_frame_scheduler #(
        .LEDS(LEDS), .CLK_DIV(CLK_DIV), .LATCH_CYCLES(LATCH_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .SDO(SDO), .CKO(CKO), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Registered producers: data for pix_idx appears one cycle later.
    logic [23:0] frame [2][LEDS];
    always @(posedge clk) bus.pix_data <= bus.grant[1] ? frame[1][bus.pix_idx] : frame[0][bus.pix_idx];

    // WS2801 chain model and scoreboard, sampled on the falling edge.
    logic [NBITS-1:0] shift_in = '0;
    logic [NBITS-1:0] led_disp = '0;
    logic prev_cko = 1'b0, prev_sdo = 1'b0, exp_bit;
    int   bit_cnt = 0, rise_cnt = 0, low_run = 0, hi_toggle = 0, done_cnt = 0;
    int   low_runs[$];
    logic sdo_exp_q[$];
    exp_t exp_q[$];
    exp_t e;

    always @(negedge clk) begin
        if (CKO === 1'b1 && prev_cko === 1'b0) begin
            if (bit_cnt < NBITS) shift_in[NBITS-1-bit_cnt] = SDO;
            bit_cnt++;
            rise_cnt++;
            low_runs.push_back(low_run);
            low_run = 0;
            if (sdo_exp_q.size() > 0) begin
                exp_bit = sdo_exp_q.pop_front();
                checks++;
                if (SDO !== exp_bit) begin
                    errors++;
                    $display("FAIL sdo_bit rise %0d: got %b expected %b", rise_cnt, SDO, exp_bit);
                end
            end
        end
        if (CKO === 1'b0) begin
            low_run++;
            if (low_run == LATCH_DETECT && bit_cnt > 0) begin
                led_disp = shift_in;
                bit_cnt  = 0;
            end
        end
        if (CKO === 1'b1 && SDO !== prev_sdo) hi_toggle++;
        prev_cko = CKO;
        prev_sdo = SDO;
        if (bus.done === 1'b1) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: done pulsed with no frame expected (grant %b)", bus.grant);
            end else begin
                e = exp_q.pop_front();
                if (bus.grant !== e.grant || led_disp !== e.pix) begin
                    errors++;
                    $display("FAIL frame_leds: grant %b leds %h expected grant %b leds %h",
                             bus.grant, led_disp, e.grant, e.pix);
                end
            end
        end
    end

    function automatic logic [NBITS-1:0] pack3(input logic [23:0] p0, input logic [23:0] p1, input logic [23:0] p2);
        return {p0, p1, p2};
    endfunction

    task automatic push_exp(input logic [1:0] g, input logic [NBITS-1:0] pix);
        exp_t x;
        x.grant = g;
        x.pix   = pix;
        exp_q.push_back(x);
    endtask

    // Drives one frame request and follows it to done; holds r until hold_rises CKO rises, then r_after.
    task automatic run_frame(input logic [1:0] r, input logic [1:0] r_after, input int hold_rises,
                             input logic [1:0] exp_grant, input logic [NBITS-1:0] pix,
                             output logic [1:0] got_grant, output int done_idx,
                             output logic [1:0] grant_after, output bit timed_out);
        int n;
        int r0;
        timed_out   = 1'b0;
        done_idx    = 0;
        got_grant   = 2'b00;
        grant_after = 2'bxx;
        push_exp(exp_grant, pix);
        bus.req = r;
        n = 0;
        while (bus.grant === 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.grant === 2'b00) begin
            timed_out = 1'b1;
            bus.req   = 2'b00;
            return;
        end
        got_grant = bus.grant;
        r0 = rise_cnt;
        n  = 1;
        while (bus.done !== 1'b1 && n < 2000) begin
            if (rise_cnt - r0 >= hold_rises) bus.req = r_after;
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) timed_out = 1'b1;
        done_idx = n;
        @(negedge clk);
        grant_after = bus.grant;
    endtask

    task automatic reset_and_wait();
        int n;
        bus.req = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        int n, busy_hi;
        frame[0][0] = 24'h010203; frame[0][1] = 24'h040506; frame[0][2] = 24'h070809;
        bus.req = 2'b01;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (SDO !== 1'b0 || CKO !== 1'b0 || bus.grant !== 2'b00 || bus.done !== 1'b0 || bus.pix_idx !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: SDO %b CKO %b grant %b done %b pix_idx %0d busy %b expected 0 0 00 0 0 1",
                     SDO, CKO, bus.grant, bus.done, bus.pix_idx, busy);
        end
        push_exp(2'b01, pack3(24'h010203, 24'h040506, 24'h070809));
        n = 0;
        busy_hi = 0;
        while (bus.grant === 2'b00 && n < 100) begin
            if (busy === 1'b1) busy_hi++;
            @(negedge clk);
            n++;
        end
        bus.req = 2'b00;
        checks++;
        if (busy_hi != LATCH_CYCLES) begin
            errors++;
            $display("FAIL reset_gap_busy: busy high for %0d cycles expected %0d", busy_hi, LATCH_CYCLES);
        end
        checks++;
        if (n != LATCH_CYCLES + 1 || bus.grant !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: grant %b at cycle %0d expected 01 at cycle %0d", bus.grant, n, LATCH_CYCLES + 1);
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL reset_frame_done: done %b after %0d cycles expected 1", bus.done, n);
        end
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [1:0] g, ga;
        int idx, r0, d0;
        bit to;
        frame[0][0] = 24'hFF0000; frame[0][1] = 24'h00FF00; frame[0][2] = 24'h0000FF;
        r0 = rise_cnt;
        d0 = done_cnt;
        run_frame(2'b01, 2'b00, 0, 2'b01, pack3(24'hFF0000, 24'h00FF00, 24'h0000FF), g, idx, ga, to);
        checks++;
        if (to !== 1'b0 || g !== 2'b01) begin
            errors++;
            $display("FAIL single_grant: grant %b timeout %b expected 01 and no timeout", g, to);
        end
        checks++;
        if (idx != GRANT_SPAN) begin
            errors++;
            $display("FAIL single_done_timing: done on grant cycle %0d expected %0d", idx, GRANT_SPAN);
        end
        checks++;
        if (ga !== 2'b00) begin
            errors++;
            $display("FAIL single_grant_fall: grant %b after done expected 00", ga);
        end
        checks++;
        if (rise_cnt - r0 != NBITS) begin
            errors++;
            $display("FAIL single_cko_rises: %0d rises expected %0d", rise_cnt - r0, NBITS);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL single_done_count: %0d done pulses expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g, ga;
        logic [1:0] exp_g;
        int idx, d0;
        bit to;
        reset_and_wait();
        frame[0][0] = 24'h111111; frame[0][1] = 24'h222222; frame[0][2] = 24'h333333;
        frame[1][0] = 24'hC0FFEE; frame[1][1] = 24'hBADA55; frame[1][2] = 24'h0D15EA;
        d0 = done_cnt;
        for (int k = 0; k < 3; k++) begin
            exp_g = (k == 1) ? 2'b10 : 2'b01;
            run_frame(2'b11, (k == 2) ? 2'b00 : 2'b11, 0, exp_g,
                      (k == 1) ? pack3(24'hC0FFEE, 24'hBADA55, 24'h0D15EA)
                               : pack3(24'h111111, 24'h222222, 24'h333333),
                      g, idx, ga, to);
            checks++;
            if (to !== 1'b0 || g !== exp_g || idx != GRANT_SPAN) begin
                errors++;
                $display("FAIL rr_grant_%0d: grant %b done_cycle %0d timeout %b expected %b %0d 0",
                         k, g, idx, to, exp_g, GRANT_SPAN);
            end
        end
        checks++;
        if (done_cnt - d0 != 3) begin
            errors++;
            $display("FAIL rr_done_count: %0d done pulses expected 3", done_cnt - d0);
        end
    endtask

    task automatic test_pixel_timing();
        logic [1:0] g, ga;
        logic [NBITS-1:0] pix;
        int idx;
        bit to;
        frame[0][0] = 24'hA5A5A5; frame[0][1] = 24'h5A5A5A; frame[0][2] = 24'h3C3C3C;
        pix = pack3(24'hA5A5A5, 24'h5A5A5A, 24'h3C3C3C);
        for (int b = NBITS - 1; b >= 0; b--) sdo_exp_q.push_back(pix[b]);
        low_runs.delete();
        hi_toggle = 0;
        run_frame(2'b01, 2'b00, 0, 2'b01, pix, g, idx, ga, to);
        checks++;
        if (to !== 1'b0 || sdo_exp_q.size() != 0) begin
            errors++;
            $display("FAIL pixel_bits_consumed: %0d bits left timeout %b expected 0 0", sdo_exp_q.size(), to);
        end
        checks++;
        if (hi_toggle != 0) begin
            errors++;
            $display("FAIL sdo_stable_high: %0d SDO changes while CKO high expected 0", hi_toggle);
        end
        checks++;
        if (low_runs.size() != NBITS || low_runs[1] != CLK_DIV || low_runs[23] != CLK_DIV) begin
            errors++;
            $display("FAIL cko_low_in_pixel: rises %0d low[1] %0d low[23] %0d expected %0d %0d %0d",
                     low_runs.size(), low_runs[1], low_runs[23], NBITS, CLK_DIV, CLK_DIV);
        end
        checks++;
        if (low_runs[24] != CLK_DIV + 2 || low_runs[48] != CLK_DIV + 2) begin
            errors++;
            $display("FAIL cko_low_between_pixels: low[24] %0d low[48] %0d expected %0d", low_runs[24], low_runs[48], CLK_DIV + 2);
        end
    endtask

    task automatic test_req_drop();
        logic [1:0] g, ga;
        int idx, d0, regrants;
        bit to;
        frame[0][0] = 24'h0F0F0F; frame[0][1] = 24'hF0F0F0; frame[0][2] = 24'h00AA55;
        d0 = done_cnt;
        run_frame(2'b01, 2'b00, 30, 2'b01, pack3(24'h0F0F0F, 24'hF0F0F0, 24'h00AA55), g, idx, ga, to);
        checks++;
        if (to !== 1'b0 || idx != GRANT_SPAN || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL drop_completes: done_cycle %0d pulses %0d timeout %b expected %0d 1 0", idx, done_cnt - d0, to, GRANT_SPAN);
        end
        regrants = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.grant !== 2'b00 || busy !== 1'b0) regrants++;
            @(negedge clk);
        end
        checks++;
        if (regrants != 0) begin
            errors++;
            $display("FAIL drop_no_regrant: %0d cycles granted or busy expected 0", regrants);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [1:0] g, ga;
        int idx, n, r0, d0;
        bit to;
        frame[0][0] = 24'hFFFFFF; frame[0][1] = 24'hFFFFFF; frame[0][2] = 24'hFFFFFF;
        bus.req = 2'b01;
        n = 0;
        while (bus.grant === 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        r0 = rise_cnt;
        while (rise_cnt - r0 < 30 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        while (CKO !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (CKO !== 1'b1 || bus.pix_idx !== 2'd1) begin
            errors++;
            $display("FAIL abort_setup: CKO %b pix_idx %0d expected 1 1", CKO, bus.pix_idx);
        end
        bus.req = 2'b00;
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (CKO !== 1'b0 || bus.grant !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: CKO %b grant %b busy %b expected 0 00 1", CKO, bus.grant, busy);
        end
        n = 1;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != LATCH_CYCLES + 1) begin
            errors++;
            $display("FAIL abort_gap: busy dropped on cycle %0d expected %0d", n, LATCH_CYCLES + 1);
        end
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL abort_no_done: %0d done pulses expected 0", done_cnt - d0);
        end
        frame[0][0] = 24'h123456; frame[0][1] = 24'h789ABC; frame[0][2] = 24'hDEF012;
        run_frame(2'b01, 2'b00, 0, 2'b01, pack3(24'h123456, 24'h789ABC, 24'hDEF012), g, idx, ga, to);
        checks++;
        if (to !== 1'b0 || g !== 2'b01 || idx != GRANT_SPAN) begin
            errors++;
            $display("FAIL after_abort_frame: grant %b done_cycle %0d timeout %b expected 01 %0d 0", g, idx, to, GRANT_SPAN);
        end
    endtask

    initial begin
        bus.req = 2'b00;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < LEDS; j++) frame[i][j] = '0;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_pixel_timing();
        test_req_drop();
        test_reset_mid_frame();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d frames never completed expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
- Sequences transmission of complete LED frames into the WS2801 chain on SDO/CKO.
- Arbitrates the chain between two frame producers: requester 0 is the visualizer and requester 1 is the test-pattern generator.
- Fetches 24-bit pixels from the granted producer, shifts them out MSB-first, then holds the ≥500 µs latch gap before signalling done.
- Sits between the frame producers and the physical LED bar.

Parameters:
- LEDS, 50: number of WS2801s in the chain (pixels per frame).
- CLK_DIV, 4: clk cycles per half CKO period; bit period = 2*CLK_DIV cycles.
- LATCH_CYCLES, 25000: clk cycles of idle CKO-low required for WS2801 latch (500 µs at 50 MHz).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  frame request per requester, level; held until granted.
- grant  out  2  one-hot; high from frame start through the done cycle; the granted requester holds its frame stable while its grant is high.
- pix_idx  out  $clog2(LEDS)  pixel index being fetched; 0 is nearest the driver.
- pix_data  in  24  pixel from the granted requester, {R,G,B}, valid one cycle after pix_idx.
- SDO  out  1  serial data to LED[0].SDI.
- CKO  out  1  serial clock to LED[0].CKI.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the latch gap of a granted frame completes.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst).
- Reset values at the edge where rst=1: SDO=0, CKO=0, grant=0, done=0, pix_idx=0, busy=1, state=GAP, gap counter=0, rr_last=1.
- Reset mid-frame: the shift is abandoned at that edge and CKO goes low. GAP lets the chain latch the partial data before any new frame. No done is issued for an aborted frame.
- GAP (reset only): CKO=SDO=0. After LATCH_CYCLES cycles go to IDLE. Requests are ignored here. done is not pulsed.
- IDLE: busy=0.
  - On a cycle with req!=0, choose the winner and go to FETCH. grant goes high on that same edge.
  - Single requester: it wins.
  - Both requesting: the one != rr_last wins, then rr_last is set to the winner. After reset, requester 0 therefore wins a tie.
- FETCH (1 cycle): drive pix_idx = current pixel. Go to LOAD.
- LOAD (1 cycle): register pix_data into a 24-bit shift register. Set bit count=23. Go to SHIFT.
- SHIFT, per bit: for CLK_DIV cycles CKO=0 and SDO=shreg[23]; then for CLK_DIV cycles CKO=1 and SDO held.
  - SDO changes only while CKO is low; WS2801 samples on the CKO rising edge.
  - After the high phase of bit 0: if pixel < LEDS-1, increment pixel and go to FETCH; otherwise go to LATCH.
  - CKO stays low through FETCH/LOAD (2-cycle stretched low between pixels).
- Cycles per pixel = 2 + 48*CLK_DIV. Frame shift cycles = LEDS*(2 + 48*CLK_DIV).
- LATCH: CKO=0, SDO=0 for LATCH_CYCLES cycles, then DONE.
- DONE (1 cycle): done=1, grant still high. Next edge: grant=0, state IDLE. A request seen in IDLE can be granted the cycle after that.
- Mid-frame requester behaviour:
  - A req drop mid-frame is ignored; the frame completes and done still pulses.
  - A new req from the other requester waits until IDLE.
- Counters: the gap counter is wide enough for LATCH_CYCLES with no wrap. pix_idx never exceeds LEDS-1.
- pix_data bit 23 (R MSB) is the first bit out; bit 0 (B LSB) is the last bit of each pixel.

Test Plan:
Setup for all scenarios: LEDS=3, CLK_DIV=2, LATCH_CYCLES=20, chain of 3 LEDModels on SDO/CKO, checked with a checkLEDs-style task.
- Reset gap: assert rst for 1 cycle with req=2'b01 held → grant stays 0 and busy stays 1 for 20 cycles, then grant=01 one cycle after IDLE is entered.
- Single frame: req[0]; pixels 0xFF0000, 0x00FF00, 0x0000FF → LEDs show those values; 72 CKO rising edges; done pulses exactly 3*98+20+1 cycles after grant rises; grant falls the cycle after done.
- Tie and round-robin: req=2'b11 from IDLE → first grant=01, second grant=10, third grant=01. Each done pulses once, and the LEDs hold the matching requester's pattern.
- Pixel timing: pixel 0 = 0xA5A5A5 → SDO is 1,0,1,0,0,1,0,1 repeated, sampled at CKO rises. SDO never toggles while CKO=1. CKO is low for 4 cycles between pixels (2 half-period + FETCH/LOAD).
- Request drop: deassert req[0] mid-SHIFT of pixel 1 → frame completes, done pulses, and there is no re-grant without a new req.
- Reset mid-frame: rst during pixel 1 → CKO=0 next cycle, no done, 20-cycle gap. A subsequent frame for 0x123456, 0x789ABC, 0xDEF012 displays correctly.
